// File: rtl/program_rom_loader.sv
// Writes the HPS ioctl program-ROM download into the five 8 KB program RAMs
// and holds the CPU in reset until a complete image has been written.
module program_rom_loader #(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter int unsigned PROG_BYTES = 40960,
  parameter int unsigned WR_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [4:0]  rom_we,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {IDLE, LOADING, WRITE, DONE} state_t;

  localparam logic [24:0] ADDR_LIMIT = 25'(PROG_BYTES);
  localparam logic [15:0] COUNT_FULL = 16'(PROG_BYTES);
  localparam logic [1:0]  LAST_BEAT  = 2'(WR_CYCLES - 1);

  state_t      state, state_nx;
  logic [15:0] byte_cnt;
  logic [1:0]  beat;
  logic [2:0]  chip_sel;
  logic        open_match;
  logic        in_range;
  logic        accept;
  logic        close_short;

  assign open_match  = ioctl_download && (ioctl_index == ROM_INDEX);
  assign in_range    = ioctl_addr < ADDR_LIMIT;
  assign accept      = (state == LOADING) && ioctl_wr && in_range;
  assign close_short = (state == LOADING) && !ioctl_wr && !ioctl_download &&
                       (byte_cnt != COUNT_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (open_match) state_nx = LOADING;
      LOADING: begin
        if (ioctl_wr) begin
          if (in_range) state_nx = WRITE;
        end else if (!ioctl_download) begin
          state_nx = (byte_cnt == COUNT_FULL) ? DONE : IDLE;
        end
      end
      // A falling download window is picked up once back in LOADING.
      WRITE:   if (beat == LAST_BEAT) state_nx = LOADING;
      DONE:    if (open_match) state_nx = LOADING;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rom_we     = '0;
    ioctl_wait = 1'b0;
    if (state == WRITE) begin
      rom_we     = 5'b00001 << chip_sel;
      ioctl_wait = 1'b1;
    end
    cpu_reset = (state != DONE);
    load_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt   <= '0;
      checksum   <= '0;
      load_error <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      chip_sel   <= '0;
      beat       <= '0;
    end else begin
      if (((state == IDLE) || (state == DONE)) && open_match) begin
        byte_cnt   <= '0;
        checksum   <= '0;
        load_error <= 1'b0;
      end
      // Count and sum are booked on the edge that starts the strobe.
      if (accept) begin
        chip_sel <= ioctl_addr[15:13];
        rom_addr <= ioctl_addr[12:0];
        rom_data <= ioctl_dout;
        beat     <= '0;
        checksum <= checksum + ioctl_dout;
        if (byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
      end
      if (state == WRITE) begin
        beat <= beat + 2'd1;
        if (ioctl_wr) load_error <= 1'b1;
      end
      if (close_short) load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_rom_loader.sv
// Bench for program_rom_loader: a reduced-size image (2 chips, 1-clock strobe)
// for the full ramp/DONE paths and a full-size, 3-clock-strobe instance.
module tb_program_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        dl    [2];
  logic [7:0]  idx   [2];
  logic        wr    [2];
  logic [24:0] addr  [2];
  logic [7:0]  dout  [2];
  logic        wait_o[2];
  logic [12:0] raddr [2];
  logic [7:0]  rdata [2];
  logic [4:0]  we    [2];
  logic        cpur  [2];
  logic        done  [2];
  logic        err   [2];
  logic [7:0]  csum  [2];

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned mcnt [2];
  logic [7:0]  msum [2];

  always #5 clk = ~clk;

  program_rom_loader #(.ROM_INDEX(8'd0), .PROG_BYTES(16384), .WR_CYCLES(1)) dut_s (
    .clk(clk), .reset_n(rst_n[0]), .ioctl_download(dl[0]), .ioctl_index(idx[0]),
    .ioctl_wr(wr[0]), .ioctl_addr(addr[0]), .ioctl_dout(dout[0]), .ioctl_wait(wait_o[0]),
    .rom_addr(raddr[0]), .rom_data(rdata[0]), .rom_we(we[0]), .cpu_reset(cpur[0]),
    .load_done(done[0]), .load_error(err[0]), .checksum(csum[0]));

  program_rom_loader #(.ROM_INDEX(8'd0), .PROG_BYTES(40960), .WR_CYCLES(3)) dut_d (
    .clk(clk), .reset_n(rst_n[1]), .ioctl_download(dl[1]), .ioctl_index(idx[1]),
    .ioctl_wr(wr[1]), .ioctl_addr(addr[1]), .ioctl_dout(dout[1]), .ioctl_wait(wait_o[1]),
    .rom_addr(raddr[1]), .rom_data(rdata[1]), .rom_we(we[1]), .cpu_reset(cpur[1]),
    .load_done(done[1]), .load_error(err[1]), .checksum(csum[1]));

  typedef struct {
    logic [24:0] off;
    logic [7:0]  data;
    logic [4:0]  we;
    logic [12:0] addr;
  } vec_t;

  vec_t vt[10];

  function automatic int unsigned plim(int d);
    return (d == 0) ? 32'd16384 : 32'd40960;
  endfunction

  function automatic int unsigned wcyc(int d);
    return (d == 0) ? 32'd1 : 32'd3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(int d, logic exp_done, logic exp_err);
    chk("load_done", 32'(done[d]), 32'(exp_done));
    chk("cpu_reset", 32'(cpur[d]), 32'(!exp_done));
    chk("load_error", 32'(err[d]), 32'(exp_err));
  endtask

  task automatic open_dl(int d, logic [7:0] ix);
    dl[d] = 1'b1;
    idx[d] = ix;
    tick();
    if (ix == 8'd0) begin
      mcnt[d] = 0;
      msum[d] = 8'h00;
      chk_status(d, 1'b0, 1'b0);
      chk("checksum_clr", 32'(csum[d]), 32'h0);
    end
  endtask

  task automatic close_dl(int d);
    logic full;
    dl[d] = 1'b0;
    tick();
    full = (mcnt[d] == plim(d));
    chk_status(d, full, !full);
    chk("checksum", 32'(csum[d]), 32'(msum[d]));
  endtask

  // One ioctl byte; the strobe is predicted from offset arithmetic alone.
  task automatic send(int d, logic [24:0] off, logic [7:0] b);
    logic ok;
    logic [4:0] ewe;
    ok  = 32'(off) < plim(d);
    ewe = ok ? 5'(32'd1 << (32'(off) / 8192)) : 5'd0;
    wr[d] = 1'b1; addr[d] = off; dout[d] = b;
    tick();
    wr[d] = 1'b0;
    for (int c = 0; c < int'(wcyc(d)); c++) begin
      chk("rom_we", 32'(we[d]), 32'(ewe));
      chk("ioctl_wait", 32'(wait_o[d]), 32'(ok));
      if (ok) begin
        chk("rom_addr", 32'(raddr[d]), 32'(off) % 8192);
        chk("rom_data", 32'(rdata[d]), 32'(b));
      end
      tick();
    end
    chk("rom_we_idle", 32'(we[d]), 32'h0);
    if (ok) begin
      if (mcnt[d] < 65535) mcnt[d]++;
      msum[d] = msum[d] + b;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; dl[d] = 1'b0; idx[d] = 8'd0; wr[d] = 1'b0;
      addr[d] = '0; dout[d] = '0; mcnt[d] = 0; msum[d] = 8'h00;
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_we", 32'(we[d]), 32'h0);
      chk("rst_wait", 32'(wait_o[d]), 32'h0);
      chk("rst_addr", 32'(raddr[d]), 32'h0);
      chk("rst_data", 32'(rdata[d]), 32'h0);
      chk("rst_csum", 32'(csum[d]), 32'h0);
      chk_status(d, 1'b0, 1'b0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    // Full ramp into the reduced image, then out-of-range bytes appended.
    open_dl(0, 8'd0);
    for (int i = 0; i < 16384; i++) send(0, 25'(i), 8'(i));
    for (int i = 0; i < 256; i++) send(0, 25'(32'hA000 + i), 8'(i));
    for (int i = 0; i < 16; i++) send(0, 25'(16384 + i), 8'hFF);
    close_dl(0);
    chk("ramp_csum_zero", 32'(csum[0]), 32'h0);
    chk("ramp_done", 32'(done[0]), 32'h1);

    // Re-download after DONE releases load_done on the very next clock.
    dl[0] = 1'b1; idx[0] = 8'd0;
    tick();
    mcnt[0] = 0; msum[0] = 8'h00;
    chk_status(0, 1'b0, 1'b0);
    send(0, 25'h1234, 8'hAB);
    close_dl(0);

    // Non-matching index: no strobes, error flag untouched, stays idle.
    open_dl(0, 8'd1);
    chk_status(0, 1'b0, 1'b1);
    wr[0] = 1'b1; addr[0] = 25'h10; dout[0] = 8'h5C;
    tick();
    wr[0] = 1'b0;
    chk("idx1_we", 32'(we[0]), 32'h0);
    chk("idx1_wait", 32'(wait_o[0]), 32'h0);
    tick();
    chk("idx1_we2", 32'(we[0]), 32'h0);
    dl[0] = 1'b0;
    tick();
    chk_status(0, 1'b0, 1'b1);

    // Reset in the middle of a strobe.
    open_dl(0, 8'd0);
    wr[0] = 1'b1; addr[0] = 25'h2005; dout[0] = 8'hC3;
    tick();
    wr[0] = 1'b0;
    chk("pre_rst_we", 32'(we[0]), 32'h02);
    chk("pre_rst_addr", 32'(raddr[0]), 32'h0005);
    rst_n[0] = 1'b0; dl[0] = 1'b0;
    tick();
    chk("midrst_we", 32'(we[0]), 32'h0);
    chk("midrst_wait", 32'(wait_o[0]), 32'h0);
    chk("midrst_addr", 32'(raddr[0]), 32'h0);
    chk("midrst_data", 32'(rdata[0]), 32'h0);
    chk("midrst_csum", 32'(csum[0]), 32'h0);
    chk_status(0, 1'b0, 1'b0);
    rst_n[0] = 1'b1;

    // Three-clock strobe with a write arriving mid-strobe.
    open_dl(1, 8'd0);
    wr[1] = 1'b1; addr[1] = 25'h4003; dout[1] = 8'h5A;
    tick();
    wr[1] = 1'b0;
    chk("w3_we_n1", 32'(we[1]), 32'h04);
    chk("w3_wait_n1", 32'(wait_o[1]), 32'h1);
    tick();
    chk("w3_we_n2", 32'(we[1]), 32'h04);
    wr[1] = 1'b1; addr[1] = 25'h10; dout[1] = 8'hFF;
    tick();
    wr[1] = 1'b0;
    chk("w3_we_n3", 32'(we[1]), 32'h04);
    chk("w3_wait_n3", 32'(wait_o[1]), 32'h1);
    chk("w3_addr_n3", 32'(raddr[1]), 32'h0003);
    chk("w3_data_n3", 32'(rdata[1]), 32'h5A);
    chk("w3_drop_err", 32'(err[1]), 32'h1);
    tick();
    chk("w3_we_n4", 32'(we[1]), 32'h0);
    chk("w3_wait_n4", 32'(wait_o[1]), 32'h0);
    chk("w3_csum", 32'(csum[1]), 32'h5A);
    mcnt[1] = 1; msum[1] = 8'h5A;

    vt[0] = '{25'h0000000, 8'h11, 5'b00001, 13'h0000};
    vt[1] = '{25'h0001FFF, 8'h22, 5'b00001, 13'h1FFF};
    vt[2] = '{25'h0002000, 8'h33, 5'b00010, 13'h0000};
    vt[3] = '{25'h0002005, 8'h05, 5'b00010, 13'h0005};
    vt[4] = '{25'h0004000, 8'h44, 5'b00100, 13'h0000};
    vt[5] = '{25'h0007FFF, 8'h55, 5'b01000, 13'h1FFF};
    vt[6] = '{25'h0008000, 8'h66, 5'b10000, 13'h0000};
    vt[7] = '{25'h0009FFF, 8'h77, 5'b10000, 13'h1FFF};
    vt[8] = '{25'h000A000, 8'h88, 5'b00000, 13'h0000};
    vt[9] = '{25'h1FFFFFF, 8'h99, 5'b00000, 13'h0000};
    for (int i = 0; i < 10; i++) begin
      wr[1] = 1'b1; addr[1] = vt[i].off; dout[1] = vt[i].data;
      tick();
      wr[1] = 1'b0;
      chk("vec_we", 32'(we[1]), 32'(vt[i].we));
      chk("vec_wait", 32'(wait_o[1]), 32'(vt[i].we != 5'd0));
      if (vt[i].we != 5'd0) begin
        chk("vec_addr", 32'(raddr[1]), 32'(vt[i].addr));
        chk("vec_data", 32'(rdata[1]), 32'(vt[i].data));
        mcnt[1]++;
        msum[1] = msum[1] + vt[i].data;
      end
      tick(); tick(); tick();
      chk("vec_we_idle", 32'(we[1]), 32'h0);
    end
    chk("vec_csum", 32'(csum[1]), 32'(msum[1]));

    // Random bytes, about a tenth of them beyond the image.
    for (int i = 0; i < 150; i++) begin
      logic [24:0] off;
      if ($urandom_range(0, 9) == 0) off = 25'(32'hA000 + $urandom_range(0, 255));
      else                           off = 25'($urandom_range(0, 40959));
      send(1, off, 8'($urandom));
    end
    close_dl(1);
    open_dl(1, 8'd0);
    close_dl(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
